// File: rtl/uart_rx_if.sv
// Received-word channel between the UART receiver and its consumer.
// Single-entry valid/ready output; m_data is held stable while m_valid is high.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, DATA_WIDTH bits LSB first, stop) feeding a one-entry valid/ready register.
// Word is valid on the edge after the stop sample (4P + DATA_WIDTH*8P + 8P cycles after start detection).
// No stall: a commit while the register is full and not being accepted overwrites it and pulses overrun_error.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             hwclk,
  input  logic             reset_n,
  input  logic [15:0]      prescale,
  input  logic             rxd,
  uart_rx_if.master        m_if,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun_error
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic [18:0]           cnt_q, cnt_d;
  logic [15:0]           p_q, p_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  fe_q, fe_d;
  logic                  ov_q, ov_d;

  logic                  rx_s;
  logic                  sample;
  logic                  commit;
  logic [15:0]           p_in;
  logic [18:0]           half_load;
  logic [18:0]           bit_load;

  assign rx_s      = sync_q[1];
  assign sample    = (cnt_q == 19'd0);
  assign p_in      = (prescale == 16'd0) ? 16'd1 : prescale;
  // Start check lands mid start bit, so the first load uses half a bit period.
  assign half_load = {1'b0, p_in, 2'b00} - 19'd1;
  assign bit_load  = {p_q, 3'b000} - 19'd1;

  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      p_q     <= 16'd1;
      shift_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rxd};
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = sample ? cnt_q : cnt_q - 19'd1;
    p_d     = p_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    fe_d    = 1'b0;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          p_d     = p_in;
          cnt_d   = half_load;
          state_d = S_START;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = bit_load;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d             = shift_q >> 1;
          shift_d[DATA_WIDTH-1] = rx_s;
          cnt_d               = bit_load;
          idx_d               = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (sample) begin
          if (rx_s) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A commit wins over an accept; the accepted word is simply replaced.
    data_d  = commit ? shift_q : data_q;
    valid_d = commit ? 1'b1 : (valid_q && !m_if.m_ready);
    ov_d    = commit && valid_q && !m_if.m_ready;
  end

  assign m_if.m_data   = data_q;
  assign m_if.m_valid  = valid_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_error   = fe_q;
  assign overrun_error = ov_q;

endmodule
